wvb_rd_arbiter: RTL and testbench
=================================

Name: wvb_rd_arbiter

Overview:
- Sits directly upstream of the per-event waveform-buffer read controller.
- Arbitrates round-robin over P_N_CHAN waveform buffers, drives the read controller's req/idx/dpram_mode handshake, and latches the DPRAM fill length.
- Hands each filled DPRAM to the host readout through a ready/done handshake.
- Handles multi-DPRAM events: when the read controller reports rd_ctrl_more, the arbiter re-requests on the same channel until the event is complete.

Parameters:
P_N_CHAN, 24, number of waveform buffers/channels (1..256)
P_TO_WIDTH, 16, width of ack-timeout counter; timeout fires at all-ones

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  arbitration enable; sampled only in S_IDLE
dpram_mode_cfg  in  1  0 = truncate at one DPRAM, 1 = extend across DPRAMs
wvb_not_empty  in  P_N_CHAN  per-channel "event available" flags
rd_ctrl_req  out  1  request to read controller
rd_ctrl_idx  out  8  channel index to read; also drives the WVB data/header mux
rd_ctrl_dpram_mode  out  1  registered copy of dpram_mode_cfg, frozen per event
rd_ctrl_ack  in  1  read controller acknowledge (DPRAM filled)
rd_ctrl_more  in  1  valid while ack=1: event continues in next DPRAM
rd_ctrl_dpram_len  in  16  valid while ack=1: DPRAM fill in 16-bit words
dpram_rdy  out  1  DPRAM holds data for host
dpram_len  out  16  latched fill length, valid while dpram_rdy=1
dpram_first  out  1  current DPRAM is first segment of event
dpram_last  out  1  current DPRAM is final segment of event
dpram_done  in  1  host single-cycle pulse: DPRAM consumed
busy  out  1  high in any state except S_IDLE
evt_cnt  out  32  completed events, wraps
err_ack_to  out  1  sticky: ack not seen within timeout

Behaviour:
- Reset values: all outputs 0; rd_ctrl_idx=0; last-served pointer=P_N_CHAN-1, so channel 0 is served first; fsm=S_IDLE.
- rst mid-transfer returns to S_IDLE immediately with outputs zeroed. The read controller is reset by the same rst.
- Round-robin selection is combinational from wvb_not_empty: select the lowest i in (last+1 .. last+P_N_CHAN) mod P_N_CHAN with wvb_not_empty[i]=1.
- S_IDLE:
  - If en and any flag is set: register rd_ctrl_idx=selected channel, rd_ctrl_dpram_mode=dpram_mode_cfg, and set first_flag=1.
  - Next state S_REQ. rd_ctrl_req rises on the following cycle.
- S_REQ:
  - rd_ctrl_req=1; the timeout counter increments each cycle.
  - On rd_ctrl_ack=1:
    - Drop rd_ctrl_req next cycle.
    - Latch dpram_len=rd_ctrl_dpram_len and more_q=rd_ctrl_more.
    - Set dpram_first=first_flag and dpram_last=!rd_ctrl_more.
    - Clear the counter; go to S_ACK_LOW.
  - If the counter reaches all-ones: set err_ack_to and keep waiting. Never abandon a request.
- S_ACK_LOW: rd_ctrl_req=0; wait for rd_ctrl_ack=0, then go to S_HOST with dpram_rdy=1. This guarantees ack is low before any re-request.
- S_HOST:
  - dpram_rdy=1; dpram_len, dpram_first and dpram_last are held stable.
  - On dpram_done: clear dpram_rdy and dpram_first.
    - If more_q=1: clear first_flag; go to S_REQ with the same rd_ctrl_idx.
    - Else: evt_cnt+1, last-served pointer=rd_ctrl_idx; go to S_IDLE.
- dpram_done outside S_HOST is ignored.
- rd_ctrl_req rises no earlier than 1 cycle after dpram_done, so the read controller sees a clean low→high edge.
- en or dpram_mode_cfg changes mid-event have no effect until the next S_IDLE.
- A wvb_not_empty flag dropping mid-event has no effect.
- Minimum gap between events: 1 idle cycle.
- Per-DPRAM latency: done → req is 1 cycle; ack → dpram_rdy is ≥2 cycles.
- In mode 0, rd_ctrl_more is expected to be 0. If it is 1, the arbiter still honours it.

Test Plan:
- Reset, en=1, wvb_not_empty=0x000001, ack returned 5 cycles after req with len=0x0040, more=0 → idx=0, dpram_rdy with len=64, first=last=1; on done, evt_cnt=1, busy low.
- Flags 0x000005 held constant over 4 events → service order idx 0,2,0,2; no channel starved.
- Mode 1, three segments with more=1,1,0 and lens 2048,2048,100 → three dpram_rdy windows with first=1/0/0 and last=0/0/1, same idx throughout, evt_cnt=1.
- Ack held high 3 cycles after req falls → dpram_rdy not asserted until ack=0; no second req while ack is high.
- P_TO_WIDTH=4, ack withheld 20 cycles → err_ack_to=1 at cycle 15, stays set; the transfer completes normally once ack arrives.
- rst asserted during S_HOST → next cycle all outputs 0, fsm S_IDLE; the following event is served from channel 0.

Source files
------------

// File: rtl/wvb_rd_arbiter.sv
// wvb_rd_arbiter: round-robin waveform-buffer read arbiter with per-DPRAM host handoff
module wvb_rd_arbiter #(
    parameter int P_N_CHAN   = 24,
    parameter int P_TO_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                dpram_mode_cfg,
    input  logic [P_N_CHAN-1:0] wvb_not_empty,
    output logic                rd_ctrl_req,
    output logic [7:0]          rd_ctrl_idx,
    output logic                rd_ctrl_dpram_mode,
    input  logic                rd_ctrl_ack,
    input  logic                rd_ctrl_more,
    input  logic [15:0]         rd_ctrl_dpram_len,
    output logic                dpram_rdy,
    output logic [15:0]         dpram_len,
    output logic                dpram_first,
    output logic                dpram_last,
    input  logic                dpram_done,
    output logic                busy,
    output logic [31:0]         evt_cnt,
    output logic                err_ack_to
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK_LOW, S_HOST} state_t;
    localparam logic [P_TO_WIDTH-1:0] TO_ONE = 1;
    state_t                state, state_nxt;
    logic [7:0]            last_q, sel;
    logic                  first_flag, more_q;
    logic [P_TO_WIDTH-1:0] to_cnt, to_nxt;
    wire                   any = |wvb_not_empty;
    wire                   start = (state == S_IDLE) && en && any;
    assign to_nxt = (to_cnt == '1) ? to_cnt : to_cnt + TO_ONE;
    // lowest flagged channel after last_q wins; the second pass overrides the wrapped-around first pass
    always_comb begin
        sel = '0;
        for (int i = P_N_CHAN - 1; i >= 0; i--)
            if (wvb_not_empty[i] && i <= int'(last_q)) sel = 8'(i);
        for (int i = P_N_CHAN - 1; i >= 0; i--)
            if (wvb_not_empty[i] && i > int'(last_q)) sel = 8'(i);
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end
    // next state and state-decoded handshake outputs
    always_comb begin
        state_nxt   = state;
        rd_ctrl_req = state == S_REQ;
        dpram_rdy   = state == S_HOST;
        busy        = state != S_IDLE;
        case (state)
            S_IDLE:    state_nxt = start ? S_REQ : S_IDLE;
            S_REQ:     state_nxt = rd_ctrl_ack ? S_ACK_LOW : S_REQ;
            S_ACK_LOW: state_nxt = rd_ctrl_ack ? S_ACK_LOW : S_HOST;
            S_HOST:    state_nxt = dpram_done ? (more_q ? S_REQ : S_IDLE) : S_HOST;
            default:   state_nxt = S_IDLE;
        endcase
    end
    // per-event channel/mode capture, per-DPRAM length/segment latch, timeout and event counting
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ctrl_idx        <= '0;
            rd_ctrl_dpram_mode <= 1'b0;
            last_q             <= 8'(P_N_CHAN - 1);
            first_flag         <= 1'b0;
            more_q             <= 1'b0;
            dpram_len          <= '0;
            dpram_first        <= 1'b0;
            dpram_last         <= 1'b0;
            to_cnt             <= '0;
            evt_cnt            <= '0;
            err_ack_to         <= 1'b0;
        end else begin
            if (start) begin
                rd_ctrl_idx        <= sel;
                rd_ctrl_dpram_mode <= dpram_mode_cfg;
                first_flag         <= 1'b1;
            end
            if (state == S_REQ && rd_ctrl_ack) begin
                dpram_len   <= rd_ctrl_dpram_len;
                more_q      <= rd_ctrl_more;
                dpram_first <= first_flag;
                dpram_last  <= !rd_ctrl_more;
                to_cnt      <= '0;
            end else if (state == S_REQ) begin
                to_cnt <= to_nxt;
                if (to_nxt == '1) err_ack_to <= 1'b1;
            end
            if (state == S_HOST && dpram_done) begin
                dpram_first <= 1'b0;
                if (more_q) first_flag <= 1'b0;
                else begin
                    evt_cnt <= evt_cnt + 32'd1;
                    last_q  <= rd_ctrl_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_wvb_rd_arbiter.sv
// tb_wvb_rd_arbiter: vector table plus scoreboard check of the round-robin read arbiter
module tb_wvb_rd_arbiter;
    localparam int N      = 24;
    localparam int TO_MAX = 15;
    typedef struct {
        logic [N-1:0] flags;
        bit           mode;
        int           delay;
        int           hold;
        logic [15:0]  len;
        bit           more;
        logic [7:0]   e_idx;
        bit           e_first;
        bit           e_last;
        bit           e_mode;
    } vec_t;
    typedef struct {
        logic [7:0]  idx;
        logic [15:0] len;
        bit          first;
        bit          last;
    } seg_t;
    logic         clk = 0, rst = 1, en = 0, mode_cfg = 0;
    logic [N-1:0] flags = '0;
    logic         req, dmode, rdy, first, last, busy, err;
    logic [7:0]   idx;
    logic         ack = 0, more = 0, done = 0;
    logic [15:0]  len_in = '0, dlen;
    logic [31:0]  evt;
    seg_t         sbq[$];
    vec_t         vt[10];
    int           n_cmp = 0, n_err = 0;
    bit           exp_err = 0;
    logic [31:0]  exp_evt = 0;

    always #5 clk = ~clk;

    wvb_rd_arbiter #(.P_N_CHAN(N), .P_TO_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .dpram_mode_cfg(mode_cfg), .wvb_not_empty(flags),
        .rd_ctrl_req(req), .rd_ctrl_idx(idx), .rd_ctrl_dpram_mode(dmode),
        .rd_ctrl_ack(ack), .rd_ctrl_more(more), .rd_ctrl_dpram_len(len_in),
        .dpram_rdy(rdy), .dpram_len(dlen), .dpram_first(first), .dpram_last(last),
        .dpram_done(done), .busy(busy), .evt_cnt(evt), .err_ack_to(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [N-1:0] f, input bit m, input int d, input int h,
                                input logic [15:0] l, input bit mo, input logic [7:0] ei,
                                input bit ef, input bit el, input bit em);
        vec_t v;
        v.flags = f; v.mode = m; v.delay = d; v.hold = h; v.len = l; v.more = mo;
        v.e_idx = ei; v.e_first = ef; v.e_last = el; v.e_mode = em;
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, req, 0);
        chk({tag, "_rdy"}, rdy, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_idx"}, idx, 0);
        chk({tag, "_mode"}, dmode, 0);
        chk({tag, "_len"}, dlen, 0);
        chk({tag, "_first"}, first, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_evt"}, evt, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic serve(input vec_t v, input bit stop_in_host);
        seg_t s;
        int   n;
        flags = v.flags;
        mode_cfg = v.mode;
        for (int w = 0; w < 40 && !req; w++) step();
        chk("req_seen", req, 1);
        chk("idx", idx, v.e_idx);
        chk("dpram_mode", dmode, v.e_mode);
        n = 0;
        while (1) begin
            if (n >= TO_MAX) exp_err = 1;
            chk("req_held", req, 1);
            chk("err_ack_to", err, exp_err);
            if (n == v.delay) break;
            step();
            n++;
        end
        ack = 1;
        more = v.more;
        len_in = v.len;
        s.idx = v.e_idx; s.len = v.len; s.first = v.e_first; s.last = v.e_last;
        sbq.push_back(s);
        step();
        for (int h = 1; h < v.hold; h++) begin
            chk("req_low_ack_high", req, 0);
            chk("rdy_wait_ack", rdy, 0);
            step();
        end
        ack = 0;
        more = 0;
        len_in = 16'hdead;
        chk("req_after_ack", req, 0);
        chk("rdy_early", rdy, 0);
        for (int w = 0; w < 10 && !rdy; w++) step();
        chk("rdy_seen", rdy, 1);
        s = sbq.pop_front();
        chk("dpram_len", dlen, s.len);
        chk("dpram_first", first, s.first);
        chk("dpram_last", last, s.last);
        chk("host_idx", idx, s.idx);
        step();
        chk("rdy_hold", rdy, 1);
        chk("len_hold", dlen, s.len);
        chk("err_hold", err, exp_err);
        if (stop_in_host) return;
        done = 1;
        step();
        done = 0;
        chk("rdy_after_done", rdy, 0);
        chk("first_after_done", first, 0);
        if (v.more) chk("req_after_done", req, 1);
        else begin
            exp_evt++;
            chk("busy_after_evt", busy, 0);
            chk("evt_cnt", evt, exp_evt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = mk(24'h000001, 0, 5, 1, 16'h0040, 0, 0, 1, 1, 0);
        vt[1] = mk(24'h000005, 0, 2, 1, 16'h0010, 0, 2, 1, 1, 0);
        vt[2] = mk(24'h000005, 0, 2, 1, 16'h0011, 0, 0, 1, 1, 0);
        vt[3] = mk(24'h000005, 0, 2, 1, 16'h0012, 0, 2, 1, 1, 0);
        vt[4] = mk(24'h000005, 0, 2, 1, 16'h0013, 0, 0, 1, 1, 0);
        vt[5] = mk(24'h000005, 1, 3, 1, 16'd2048, 1, 2, 1, 0, 1);
        vt[6] = mk(24'h000001, 0, 1, 1, 16'd2048, 1, 2, 0, 0, 1);
        vt[7] = mk(24'h000000, 0, 4, 1, 16'd100,  0, 2, 0, 1, 1);
        vt[8] = mk(24'h800000, 0, 0, 4, 16'h0007, 0, 23, 1, 1, 0);
        vt[9] = mk(24'h000001, 0, 20, 1, 16'h0009, 0, 0, 1, 1, 0);
        repeat (3) step();
        chk_zero("in_reset");
        rst = 0;
        step();
        chk_zero("after_reset");
        flags = 24'h000001;
        repeat (4) step();
        chk("en_low_busy", busy, 0);
        chk("en_low_req", req, 0);
        done = 1;
        step();
        done = 0;
        chk("stray_done_evt", evt, 0);
        chk("stray_done_busy", busy, 0);
        en = 1;
        for (int i = 0; i < 10; i++) serve(vt[i], 0);
        serve(mk(24'h000004, 0, 2, 1, 16'h0055, 0, 2, 1, 1, 0), 1);
        rst = 1;
        step();
        chk_zero("mid_rst");
        rst = 0;
        flags = '0;
        exp_evt = 0;
        exp_err = 0;
        serve(mk(24'h000005, 0, 1, 1, 16'h0066, 0, 0, 1, 1, 0), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
